// File: rtl/leitor_teclado.sv
// 4x4 keypad scanner: drives one column low at a time, debounces the returned
// row, and emits one ready pulse with the hex code per physical key press.
module leitor_teclado #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [3:0] valor,
  output logic       ready
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {VARRE, FILTRA, EMITE, SOLTA} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [3:0]      valor_q, valor_d;
  logic            ready_q, ready_d;
  logic [1:0]      first_low;
  logic [3:0]      code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VARRE;
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
      cnt_q   <= '0;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      valor_q <= 4'h0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= linhas;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valor_q <= valor_d;
      ready_q <= ready_d;
    end
  end

  // Lowest-index low row wins when several keys share the scanned column.
  always_comb begin
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!sync2_q[i]) first_low = 2'(i);
    end
  end

  always_comb begin
    case ({row_q, col_q})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    valor_d = valor_q;
    ready_d = 1'b0;
    case (state_q)
      VARRE: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (sync2_q != 4'b1111) begin
            row_d   = first_low;
            state_d = FILTRA;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FILTRA: begin
        if (sync2_q[row_q]) begin
          state_d = VARRE;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          // ready and valor are registered so both appear in the EMITE cycle.
          state_d = EMITE;
          cnt_d   = '0;
          ready_d = 1'b1;
          valor_d = code;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EMITE: state_d = SOLTA;
      SOLTA: begin
        if (sync2_q != 4'b1111) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = VARRE;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = VARRE;
    endcase
  end

  always_comb begin
    colunas = ~(4'b0001 << col_q);
    valor   = valor_q;
    ready   = ready_q;
  end

endmodule

// File: tb/tb_leitor_teclado.sv
// Bench for leitor_teclado with a combinational keypad model and a scoreboard
// of expected key codes consumed on each ready pulse.
module tb_leitor_teclado;

  logic       clk;
  logic       rst_n;
  logic [3:0] linhas;
  logic [3:0] colunas;
  logic [3:0] valor;
  logic       ready;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  int          total;
  int          bad;
  int          pulse_cnt;

  leitor_teclado #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .linhas(linhas),
    .colunas(colunas), .valor(valor), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r reads low only while one of its pressed keys has its column driven low.
  always_comb begin
    linhas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !colunas[c]) linhas[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && ready === 1'b1) begin
      pulse_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: valor=%h, no pulse expected", valor);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (valor !== e) begin
          bad++;
          $display("FAIL pulse_valor: got %h, expected %h", valor, e);
        end else begin
          $display("pulse valor=%h ok", valor);
        end
      end
    end
  end

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic release_key(input int r, input int c);
    pressed[r*4+c] = 1'b0;
  endtask

  task automatic wait_col(input logic [3:0] target);
    bit found;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (colunas === target) found = 1;
      else @(negedge clk);
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL wait_col timeout: colunas=%b, expected %b", colunas, target);
    end
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pulse_cnt < target) begin
      total++; bad++;
      $display("FAIL %s timeout: pulses=%0d, expected %0d", name, pulse_cnt, target);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end else begin
      $display("check %s = %b ok", name, got);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    total++;
    if (colunas !== 4'b1110 || valor !== 4'h0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL reset: colunas=%b valor=%h ready=%b, expected 1110/0/0", colunas, valor, ready);
    end else $display("reset state ok");
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_col;
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (colunas !== exp_col) begin
        bad++;
        $display("FAIL rotate cycle %0d: colunas=%b, expected %b", k, colunas, exp_col);
      end
    end
    $display("rotation checked");
  endtask

  task automatic test_press_5();
    int n;
    int p0;
    p0 = pulse_cnt;
    wait_col(4'b1110);
    press(1, 1);
    exp_q.push_back(4'h5);
    wait_col(4'b1101);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 40);
    total++;
    if (n != 12) begin
      bad++;
      $display("FAIL key5_latency: got %0d cycles, expected 12", n);
    end else $display("key5 latency 12 ok");
    repeat (100) @(negedge clk);
    check4("key5_hold_colunas", colunas, 4'b1101);
    total++;
    if (pulse_cnt - p0 != 1) begin
      bad++;
      $display("FAIL key5_pulses: got %0d, expected 1", pulse_cnt - p0);
    end
    release_key(1, 1);
    repeat (6) @(negedge clk);
    check4("key5_release_hold", colunas, 4'b1101);
    repeat (6) @(negedge clk);
    check4("key5_release_next", colunas, 4'b1011);
  endtask

  task automatic test_bounce_a();
    int p0;
    p0 = pulse_cnt;
    wait_col(4'b0111);
    press(0, 3);       repeat (5) @(negedge clk);
    release_key(0, 3); repeat (1) @(negedge clk);
    press(0, 3);       repeat (5) @(negedge clk);
    release_key(0, 3); repeat (30) @(negedge clk);
    total++;
    if (pulse_cnt != p0) begin
      bad++;
      $display("FAIL bounce_no_pulse: got %0d pulses, expected 0", pulse_cnt - p0);
    end else $display("bounce rejected ok");
    wait_col(4'b0111);
    press(0, 3);
    exp_q.push_back(4'hA);
    wait_pulses(p0 + 1, 20, "keyA_stable");
    release_key(0, 3);
    repeat (25) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    press(3, 2);
    exp_q.push_back(4'hF);
    wait_pulses(p0 + 1, 60, "keyF");
    release_key(3, 2);
    repeat (25) @(negedge clk);
    press(1, 1);
    exp_q.push_back(4'h5);
    wait_pulses(p0 + 2, 60, "key5_again");
    repeat (200) @(negedge clk);
    total++;
    if (pulse_cnt - p0 != 2) begin
      bad++;
      $display("FAIL hold_single_pulse: got %0d, expected 2", pulse_cnt - p0);
    end else $display("long hold single pulse ok");
    release_key(1, 1);
    repeat (25) @(negedge clk);
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = pulse_cnt;
    press(0, 1);
    press(2, 1);
    exp_q.push_back(4'h2);
    wait_pulses(p0 + 1, 60, "key2_8");
    release_key(0, 1);
    repeat (30) @(negedge clk);
    check4("multi_solta_wait", colunas, 4'b1101);
    release_key(2, 1);
    repeat (40) @(negedge clk);
    total++;
    if (pulse_cnt - p0 != 1) begin
      bad++;
      $display("FAIL multi_pulses: got %0d, expected 1", pulse_cnt - p0);
    end else $display("multi key single pulse ok");
  endtask

  task automatic test_reset_mid();
    int p0;
    wait_col(4'b1110);
    press(3, 3);
    wait_col(4'b0111);
    repeat (5) @(negedge clk);
    p0 = pulse_cnt;
    rst_n = 1'b0;
    #1;
    total++;
    if (colunas !== 4'b1110 || valor !== 4'h0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: colunas=%b valor=%h ready=%b, expected 1110/0/0", colunas, valor, ready);
    end else $display("mid-filter reset ok");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'hD);
    wait_pulses(p0 + 1, 60, "keyD_after_reset");
    check4("keyD_valor_held", valor, 4'hD);
    release_key(3, 3);
    repeat (25) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    pulse_cnt = 0;
    pressed = '0;
    rst_n = 1'b0;
    test_reset();
    test_press_5();
    test_bounce_a();
    test_back_to_back();
    test_multi_key();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: %0d pulses missing, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leitor_teclado.md
Name: leitor_teclado

Overview:
- Scans a 4x4 membrane keypad, synchronises and debounces the row inputs, and encodes the pressed key as a 4-bit hex code.
- Emits exactly one single-cycle ready pulse per physical press.
- Sits directly upstream of the clock-selector stage, which consumes ready and valor together with the calculator state.
- Code points used downstream: digits 0-9, operators A/B/C, equals D, spare E/F.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven during scanning (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
linhas  input  4  keypad rows, active-low (pull-ups), bit r = row r, asynchronous to clk
colunas  output  4  keypad column drive, active-low one-hot, bit c = column c
valor  output  4  hex code of last accepted key; held until next accepted key
ready  output  1  one-cycle pulse; valor is valid and new in the same cycle

Behaviour:
- Reset: one clock domain on clk; reset is asynchronous and active-low via rst_n. Reset values: colunas=4'b1110, valor=4'h0, ready=0, state=VARRE, all counters 0, synchroniser flops 4'b1111.
- Synchroniser: linhas passes through 2 flops to give linhas_s. All decisions use linhas_s only.
- Key map, row r / column c -> valor:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- State VARRE (scanning):
  - scan counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, if linhas_s != 4'b1111: capture the column index and the lowest-index low row, go to FILTRA, hold colunas.
  - Otherwise rotate colunas left (1110->1101->1011->0111->1110) and restart the counter.
- State FILTRA (press debounce):
  - stable counter increments each cycle the captured row bit of linhas_s is 0.
  - Any cycle that bit is 1: return to VARRE, advance to the next column, clear counters, no pulse.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit still 0: go to EMITE.
- State EMITE (1 cycle):
  - ready=1 and valor=mapped code, both registered and visible in this cycle.
  - Next state SOLTA.
  - ready is 0 in every other state.
- State SOLTA (release debounce):
  - colunas held.
  - Counter increments while linhas_s==4'b1111; any low bit clears it.
  - When the counter reaches DEBOUNCE_CYCLES-1: go to VARRE at the next column.
- Latency: ready rises DEBOUNCE_CYCLES+1 cycles after the VARRE detection cycle, plus the 2-cycle synchroniser delay from the pin.
- Holding a key indefinitely produces exactly one pulse. A new press is only recognised after a debounced full release.
- Multiple keys:
  - Several rows low in the scanned column: the lowest row index wins.
  - Keys in other columns are ignored until return to VARRE.
  - Releasing the captured key while another in the same column stays down keeps SOLTA waiting until all rows are released.
- Reset asserted mid-operation (any state) aborts immediately: no ready pulse, valor returns to 0, scanning restarts at column 0 after rst_n deasserts.
- Counters are sized to hold max(SCAN_DIV, DEBOUNCE_CYCLES)-1. No wrap is possible because each counter is cleared on its terminal transition.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=8, and a keypad model that pulls row r low only while its column line is low.
1. Reset: hold rst_n=0 -> colunas=1110, valor=0, ready=0. After release, colunas rotates 1110->1101->1011->0111->1110 every 4 cycles.
2. Press r1/c1 (key 5) stable for 100 cycles -> exactly one ready pulse 9 cycles after detection, with valor=4'h5. colunas stays 1101 until release plus 8 stable cycles.
3. Bounce r0/c3 (key A): low 5 cycles, high 1, low 5, high -> no ready. Then a stable 20-cycle press -> one pulse with valor=4'hA.
4. Release key 5, then press r3/c2 (#) -> second pulse with valor=4'hF. Hold key 5 without release for 200 cycles -> still only one pulse.
5. Press r0 and r2 of c1 simultaneously (keys 2 and 8) -> single pulse with valor=4'h2. No further pulse until both are released.
6. Assert rst_n=0 during FILTRA for key D (r3/c3) -> no ready, valor=0, colunas=1110. Keep D held after reset -> pulse with valor=4'hD once column 3 is scanned and debounced.
